obuf_seq: RTL and testbench

OBUF_SEQ -- requirements
Module: obuf_seq

---
 rtl/obuf_pkg.sv | 17 +
 rtl/wrap_cnt.sv | 37 +++
 rtl/obuf_seq.sv | 165 ++++++++++++++++
 tb/tb_obuf_seq.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obuf_pkg.sv
// Shared types and default sizes for the output-buffer sequencer.
package obuf_pkg;

  localparam int unsigned OBUF_WIDTH  = 19;
  localparam int unsigned OBUF_DEPTH  = 8;
  localparam int unsigned OBUF_PASS_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BIAS   = 3'd1,
    ACCUM  = 3'd2,
    RD_REQ = 3'd3,
    RD_OUT = 3'd4,
    DONE   = 3'd5
  } obuf_state_e;

endpackage

// File: rtl/wrap_cnt.sv
// Modulo counter with synchronous clear; wraps to zero after reaching max_i.
module wrap_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap_o = inc_i && (cnt_q == max_i);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/obuf_seq.sv
// Output-buffer sequencer: bias preload, multi-pass accumulate, then a
// request/present drain of every buffer entry to the result stream.
module obuf_seq
  import obuf_pkg::*;
#(
  parameter int unsigned WIDTH  = OBUF_WIDTH,
  parameter int unsigned DEPTH  = OBUF_DEPTH,
  parameter int unsigned PASS_W = OBUF_PASS_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [PASS_W-1:0]        passes_i,
  output logic                     busy_o,
  output logic                     done_o,
  input  logic [WIDTH-1:0]         bias_data_i,
  input  logic                     bias_valid_i,
  output logic                     bias_ready_o,
  input  logic [WIDTH-1:0]         psum_data_i,
  input  logic                     psum_valid_i,
  output logic                     psum_ready_o,
  output logic [WIDTH-1:0]         buf_wdata_o,
  output logic                     buf_wdata_vo,
  output logic [WIDTH-1:0]         buf_cdata_o,
  output logic                     buf_cw_vo,
  output logic [$clog2(DEPTH)-1:0] buf_raddr_o,
  input  logic [WIDTH-1:0]         buf_rdata_i,
  output logic [WIDTH-1:0]         out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     out_last_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  obuf_state_e       state_q;
  logic [PASS_W-1:0] passes_q;

  logic [AW-1:0]     idx_cnt;
  logic              idx_wrap;
  logic [PASS_W-1:0] pass_cnt;
  logic              pass_wrap;

  logic start_hs;
  logic bias_hs;
  logic psum_hs;
  logic out_hs;
  logic idx_last;

  assign start_hs = (state_q == IDLE)   && start_i;
  assign bias_hs  = (state_q == BIAS)   && bias_valid_i;
  assign psum_hs  = (state_q == ACCUM)  && psum_valid_i;
  assign out_hs   = (state_q == RD_OUT) && out_ready_i;
  assign idx_last = (idx_cnt == AW'(DEPTH - 1));

  // One counter serves as entry index in BIAS/drain and as beat index in ACCUM.
  wrap_cnt #(
    .W (AW)
  ) u_idx_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (start_hs),
    .inc_i  (bias_hs || psum_hs || out_hs),
    .max_i  (AW'(DEPTH - 1)),
    .cnt_o  (idx_cnt),
    .wrap_o (idx_wrap)
  );

  // Pass counter wraps exactly when the final beat of the final pass lands.
  wrap_cnt #(
    .W (PASS_W)
  ) u_pass_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (start_hs),
    .inc_i  (psum_hs && idx_wrap),
    .max_i  (passes_q - PASS_W'(1)),
    .cnt_o  (pass_cnt),
    .wrap_o (pass_wrap)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      passes_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q  <= BIAS;
            passes_q <= passes_i;
          end
        end
        BIAS: begin
          if (bias_hs && idx_wrap) begin
            state_q <= (passes_q == '0) ? RD_REQ : ACCUM;
          end
        end
        ACCUM: begin
          if (pass_wrap) begin
            state_q <= RD_REQ;
          end
        end
        RD_REQ: state_q <= RD_OUT;
        RD_OUT: begin
          if (out_hs) begin
            state_q <= idx_last ? DONE : RD_REQ;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register; stream data passes straight through.
  always_comb begin
    busy_o       = 1'b0;
    done_o       = 1'b0;
    bias_ready_o = 1'b0;
    psum_ready_o = 1'b0;
    out_valid_o  = 1'b0;
    out_last_o   = 1'b0;
    out_data_o   = '0;
    buf_wdata_o  = '0;
    buf_wdata_vo = 1'b0;
    buf_cdata_o  = '0;
    buf_cw_vo    = 1'b0;
    buf_raddr_o  = '0;
    if (rst_i) begin
      busy_o = (state_q != IDLE);
      case (state_q)
        BIAS: begin
          bias_ready_o = 1'b1;
          buf_raddr_o  = idx_cnt;
          buf_cdata_o  = bias_data_i;
          buf_cw_vo    = bias_valid_i;
        end
        ACCUM: begin
          psum_ready_o = 1'b1;
          buf_wdata_o  = psum_data_i;
          buf_wdata_vo = psum_valid_i;
        end
        RD_REQ: begin
          buf_raddr_o = idx_cnt;
        end
        RD_OUT: begin
          buf_raddr_o = idx_cnt;
          out_valid_o = 1'b1;
          out_data_o  = buf_rdata_i;
          out_last_o  = idx_last;
        end
        DONE: begin
          done_o = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  a_strobe_excl: assert property (@(posedge clk_i) !(buf_cw_vo && buf_wdata_vo));
  a_done_pulse:  assert property (@(posedge clk_i) disable iff (!rst_i) done_o |=> !done_o);

endmodule

// File: tb/tb_obuf_seq.sv
// Randomised bench for obuf_seq with a behavioural buffer and result model.
module tb_obuf_seq;

  localparam int WIDTH  = 19;
  localparam int DEPTH  = 8;
  localparam int PASS_W = 8;
  localparam int AW     = 3;
  localparam int MAX_CYC = 3000;

  logic              clk_i;
  logic              rst_i;
  logic              start_i;
  logic [PASS_W-1:0] passes_i;
  logic              busy_o, done_o;
  logic [WIDTH-1:0]  bias_data_i;
  logic              bias_valid_i, bias_ready_o;
  logic [WIDTH-1:0]  psum_data_i;
  logic              psum_valid_i, psum_ready_o;
  logic [WIDTH-1:0]  buf_wdata_o;
  logic              buf_wdata_vo;
  logic [WIDTH-1:0]  buf_cdata_o;
  logic              buf_cw_vo;
  logic [AW-1:0]     buf_raddr_o;
  logic [WIDTH-1:0]  buf_rdata_i;
  logic [WIDTH-1:0]  out_data_o;
  logic              out_valid_o, out_ready_i, out_last_o;

  obuf_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PASS_W(PASS_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .passes_i(passes_i),
    .busy_o(busy_o), .done_o(done_o),
    .bias_data_i(bias_data_i), .bias_valid_i(bias_valid_i), .bias_ready_o(bias_ready_o),
    .psum_data_i(psum_data_i), .psum_valid_i(psum_valid_i), .psum_ready_o(psum_ready_o),
    .buf_wdata_o(buf_wdata_o), .buf_wdata_vo(buf_wdata_vo),
    .buf_cdata_o(buf_cdata_o), .buf_cw_vo(buf_cw_vo),
    .buf_raddr_o(buf_raddr_o), .buf_rdata_i(buf_rdata_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_last_o(out_last_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp, n_bad;

  logic [WIDTH-1:0] bias_arr [DEPTH];
  logic [WIDTH-1:0] psum_arr [256];

  int bias_hs, psum_hs, wv_cnt, overlap_cnt, stray_cnt, done_cnt;
  int               cw_addr_q  [$];
  logic [WIDTH-1:0] out_data_q [$];
  bit               out_last_q [$];
  bit               bp_seen;
  int               bp_bad;
  logic [WIDTH-1:0] bp_data;

  logic [WIDTH-1:0] mem [DEPTH];
  int               wp;
  logic             s_rst, s_cw, s_wv;
  logic [AW-1:0]    s_raddr;
  logic [WIDTH-1:0] s_cdata, s_wdata;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    wp = 0; s_rst = 1'b0; s_cw = 1'b0; s_wv = 1'b0;
    s_raddr = '0; s_cdata = '0; s_wdata = '0;
    buf_rdata_i = '0;
  end

  // Mid-cycle monitor: snapshot for the buffer model and transaction logs.
  always @(negedge clk_i) begin
    s_rst = rst_i; s_cw = buf_cw_vo; s_wv = buf_wdata_vo;
    s_raddr = buf_raddr_o; s_cdata = buf_cdata_o; s_wdata = buf_wdata_o;
    if (buf_cw_vo && buf_wdata_vo) overlap_cnt++;
    if (buf_cw_vo && !bias_ready_o) stray_cnt++;
    if (buf_wdata_vo && !psum_ready_o) stray_cnt++;
    if ((!busy_o || psum_ready_o) && buf_raddr_o != '0) stray_cnt++;
    if (rst_i) begin
      if (bias_valid_i && bias_ready_o) bias_hs++;
      if (psum_valid_i && psum_ready_o) psum_hs++;
      if (buf_cw_vo) cw_addr_q.push_back(int'(buf_raddr_o));
      if (buf_wdata_vo) wv_cnt++;
      if (out_valid_o && out_ready_i) begin
        out_data_q.push_back(out_data_o);
        out_last_q.push_back(out_last_o);
      end
      if (done_o) done_cnt++;
    end
  end

  // Buffer: bias writes by address, accumulates by internal write pointer.
  always @(posedge clk_i) begin
    if (!s_rst) begin
      wp = 0;
    end else begin
      if (s_cw) mem[s_raddr] = s_cdata;
      if (s_wv) begin
        mem[wp] = mem[wp] + s_wdata;
        wp = (wp + 1) % DEPTH;
      end
    end
    buf_rdata_i <= mem[s_raddr];
  end

  function automatic logic [WIDTH-1:0] exp_word(input int i, input int passes);
    logic [WIDTH-1:0] acc;
    acc = bias_arr[i];
    for (int p = 0; p < passes; p++) acc = acc + psum_arr[(p * DEPTH + i) % 256];
    return acc;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) bias_arr[i] = WIDTH'($urandom);
    for (int i = 0; i < 256; i++) psum_arr[i] = WIDTH'($urandom);
  endtask

  task automatic do_reset();
    rst_i = 1'b0; start_i = 1'b0;
    bias_valid_i = 1'b0; psum_valid_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  // Drives one job; rmode 0: ready high, 1: random, 2: 5-cycle stall on entry 4.
  task automatic run_job(input int passes, input int vpct, input int rmode,
                         input bit hold, input bit chg, input int rst_at,
                         output bit timed_out, output bit aborted);
    bit bp_used;
    int bp_left;
    timed_out = 1'b1; aborted = 1'b0; bp_used = 1'b0; bp_left = 0;
    bias_hs = 0; psum_hs = 0; wv_cnt = 0; overlap_cnt = 0; stray_cnt = 0; done_cnt = 0;
    cw_addr_q.delete(); out_data_q.delete(); out_last_q.delete();
    bp_seen = 1'b0; bp_bad = 0;
    bias_valid_i = 1'b0; psum_valid_i = 1'b0; out_ready_i = 1'b0;
    passes_i = PASS_W'(passes); start_i = 1'b1;
    @(posedge clk_i); #1;
    if (!hold) start_i = 1'b0;
    if (chg) passes_i = PASS_W'(passes + 5);
    for (int cyc = 0; cyc < MAX_CYC; cyc++) begin
      bias_valid_i = int'($urandom_range(99)) < vpct;
      bias_data_i  = (bias_hs < DEPTH) ? bias_arr[bias_hs] : WIDTH'($urandom);
      psum_valid_i = int'($urandom_range(99)) < vpct;
      psum_data_i  = psum_arr[psum_hs % 256];
      case (rmode)
        0: out_ready_i = 1'b1;
        1: out_ready_i = 1'($urandom_range(1));
        default: begin
          if (bp_left > 0) begin
            out_ready_i = 1'b0;
            bp_left--;
            if (!out_valid_o || out_data_o !== bp_data || buf_raddr_o !== 3'd4) bp_bad++;
          end else if (!bp_used && out_valid_o && buf_raddr_o == 3'd4) begin
            bp_used = 1'b1; bp_seen = 1'b1; bp_left = 4;
            bp_data = out_data_o; out_ready_i = 1'b0;
          end else begin
            out_ready_i = 1'b1;
          end
        end
      endcase
      if (rst_at >= 0 && psum_hs == rst_at && psum_ready_o) begin
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        aborted = 1'b1; timed_out = 1'b0;
        break;
      end
      @(posedge clk_i); #1;
      if (done_cnt != 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    bias_valid_i = 1'b0; psum_valid_i = 1'b0; out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b1; passes_i = 8'd3;
    bias_valid_i = 1'b1; psum_valid_i = 1'b1; out_ready_i = 1'b1;
    bias_data_i = WIDTH'($urandom); psum_data_i = WIDTH'($urandom);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
      n_cmp++;
      if ({busy_o, done_o, bias_ready_o, psum_ready_o, out_valid_o, out_last_o,
           buf_cw_vo, buf_wdata_vo} !== 8'h00 || buf_raddr_o !== '0) begin
        n_bad++;
        $display("FAIL reset_ctl[%0d]: got %b addr %0d want 0", c,
                 {busy_o, done_o, bias_ready_o, psum_ready_o, out_valid_o, out_last_o,
                  buf_cw_vo, buf_wdata_vo}, buf_raddr_o);
      end
      n_cmp++;
      if (out_data_o !== '0 || buf_wdata_o !== '0 || buf_cdata_o !== '0) begin
        n_bad++;
        $display("FAIL reset_data[%0d]: got %0d/%0d/%0d want 0", c,
                 out_data_o, buf_wdata_o, buf_cdata_o);
      end
    end
    rst_i = 1'b1; start_i = 1'b0; bias_valid_i = 1'b0; psum_valid_i = 1'b0;
    @(posedge clk_i); #1;
    n_cmp++;
    if (busy_o !== 1'b0 || bias_ready_o !== 1'b0 || out_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: busy %b bias_rdy %b out_vld %b want 0",
               busy_o, bias_ready_o, out_valid_o);
    end
  endtask

  task automatic test_bias_only();
    bit to, ab;
    for (int i = 0; i < DEPTH; i++) bias_arr[i] = WIDTH'(i + 1);
    for (int i = 0; i < 256; i++) psum_arr[i] = WIDTH'($urandom);
    run_job(0, 100, 0, 1'b0, 1'b0, -1, to, ab);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL bias_timeout: got no done want done"); do_reset(); end
    n_cmp++;
    if (cw_addr_q.size() != DEPTH) begin
      n_bad++; $display("FAIL bias_cw_count: got %0d want %0d", cw_addr_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        n_cmp++;
        if (cw_addr_q[i] != i) begin
          n_bad++; $display("FAIL bias_cw_addr[%0d]: got %0d want %0d", i, cw_addr_q[i], i);
        end
      end
    end
    n_cmp++;
    if (wv_cnt != 0) begin n_bad++; $display("FAIL bias_wdata_count: got %0d want 0", wv_cnt); end
    n_cmp++;
    if (out_data_q.size() != DEPTH) begin
      n_bad++; $display("FAIL bias_out_count: got %0d want %0d", out_data_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        n_cmp++;
        if (out_data_q[i] !== WIDTH'(i + 1) || out_last_q[i] !== (i == DEPTH - 1)) begin
          n_bad++;
          $display("FAIL bias_out[%0d]: got %0d last %b want %0d last %b", i,
                   out_data_q[i], out_last_q[i], i + 1, i == DEPTH - 1);
        end
      end
    end
    n_cmp++;
    if (done_cnt != 1 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL bias_done: got %0d busy %b want 1 busy 0", done_cnt, busy_o);
    end
  endtask

  task automatic test_accum();
    bit to, ab;
    for (int i = 0; i < DEPTH; i++) bias_arr[i] = '0;
    for (int i = 0; i < 256; i++) psum_arr[i] = WIDTH'(1);
    run_job(3, 100, 0, 1'b0, 1'b0, -1, to, ab);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL accum_timeout: got no done want done"); do_reset(); end
    n_cmp++;
    if (wv_cnt != 24) begin n_bad++; $display("FAIL accum_wdata_count: got %0d want 24", wv_cnt); end
    n_cmp++;
    if (out_data_q.size() != DEPTH) begin
      n_bad++; $display("FAIL accum_out_count: got %0d want %0d", out_data_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        n_cmp++;
        if (out_data_q[i] !== WIDTH'(3)) begin
          n_bad++; $display("FAIL accum_out[%0d]: got %0d want 3", i, out_data_q[i]);
        end
      end
    end
    n_cmp++;
    if (wp != 0 || done_cnt != 1 || overlap_cnt != 0 || stray_cnt != 0) begin
      n_bad++;
      $display("FAIL accum_end: got wp %0d done %0d overlap %0d stray %0d want 0/1/0/0",
               wp, done_cnt, overlap_cnt, stray_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit to, ab;
    fill_random();
    run_job(2, 100, 2, 1'b0, 1'b0, -1, to, ab);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL bp_timeout: got no done want done"); do_reset(); end
    n_cmp++;
    if (!bp_seen || bp_bad != 0) begin
      n_bad++; $display("FAIL bp_stable: got seen %b unstable %0d want seen 1 unstable 0", bp_seen, bp_bad);
    end
    n_cmp++;
    if (out_data_q.size() != DEPTH) begin
      n_bad++; $display("FAIL bp_out_count: got %0d want %0d", out_data_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        n_cmp++;
        if (out_data_q[i] !== exp_word(i, 2)) begin
          n_bad++; $display("FAIL bp_out[%0d]: got %0d want %0d", i, out_data_q[i], exp_word(i, 2));
        end
      end
    end
  endtask

  task automatic test_gapped();
    bit to, ab;
    int p;
    for (int j = 0; j < 4; j++) begin
      p = int'($urandom_range(3));
      fill_random();
      run_job(p, 50, 1, 1'b0, 1'b0, -1, to, ab);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL gap_timeout[%0d]: got no done want done", j); do_reset(); end
      n_cmp++;
      if (overlap_cnt != 0 || stray_cnt != 0 || cw_addr_q.size() != DEPTH || wv_cnt != p * DEPTH) begin
        n_bad++;
        $display("FAIL gap_strobes[%0d]: got overlap %0d stray %0d cw %0d wv %0d want 0/0/%0d/%0d",
                 j, overlap_cnt, stray_cnt, cw_addr_q.size(), wv_cnt, DEPTH, p * DEPTH);
      end
      n_cmp++;
      if (out_data_q.size() != DEPTH || done_cnt != 1) begin
        n_bad++;
        $display("FAIL gap_drain[%0d]: got %0d words done %0d want %0d done 1",
                 j, out_data_q.size(), done_cnt, DEPTH);
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          n_cmp++;
          if (out_data_q[i] !== exp_word(i, p)) begin
            n_bad++;
            $display("FAIL gap_out[%0d][%0d]: got %0d want %0d", j, i, out_data_q[i], exp_word(i, p));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_accum();
    bit to, ab;
    fill_random();
    run_job(3, 70, 1, 1'b0, 1'b0, DEPTH + 5, to, ab);
    n_cmp++;
    if (!ab) begin n_bad++; $display("FAIL rst_mid_hit: got no reset point want reset in pass 2"); end
    rst_i = 1'b1; bias_valid_i = 1'b1; psum_valid_i = 1'b1; out_ready_i = 1'b1;
    n_cmp++;
    if ({busy_o, done_o, bias_ready_o, psum_ready_o, out_valid_o, out_last_o,
         buf_cw_vo, buf_wdata_vo} !== 8'h00 || buf_raddr_o !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_idle: got %b addr %0d want 0",
               {busy_o, done_o, bias_ready_o, psum_ready_o, out_valid_o, out_last_o,
                buf_cw_vo, buf_wdata_vo}, buf_raddr_o);
    end
    n_cmp++;
    if (done_cnt != 0 || wp != 0) begin
      n_bad++; $display("FAIL rst_mid_state: got done %0d wp %0d want 0/0", done_cnt, wp);
    end
    @(posedge clk_i); #1;
    bias_valid_i = 1'b0; psum_valid_i = 1'b0; out_ready_i = 1'b0;
    fill_random();
    run_job(2, 100, 0, 1'b0, 1'b0, -1, to, ab);
    n_cmp++;
    if (to || done_cnt != 1 || wv_cnt != 2 * DEPTH || out_data_q.size() != DEPTH) begin
      n_bad++;
      $display("FAIL rst_rerun: got to %b done %0d wv %0d words %0d want 0/1/%0d/%0d",
               to, done_cnt, wv_cnt, out_data_q.size(), 2 * DEPTH, DEPTH);
      if (to) do_reset();
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        n_cmp++;
        if (out_data_q[i] !== exp_word(i, 2)) begin
          n_bad++; $display("FAIL rst_rerun_out[%0d]: got %0d want %0d", i, out_data_q[i], exp_word(i, 2));
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    bit to, ab;
    fill_random();
    run_job(2, 80, 1, 1'b1, 1'b1, -1, to, ab);
    n_cmp++;
    if (to || done_cnt != 1 || cw_addr_q.size() != DEPTH || wv_cnt != 2 * DEPTH) begin
      n_bad++;
      $display("FAIL hold_job1: got to %b done %0d cw %0d wv %0d want 0/1/%0d/%0d",
               to, done_cnt, cw_addr_q.size(), wv_cnt, DEPTH, 2 * DEPTH);
      if (to) do_reset();
    end
    n_cmp++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_bad++; $display("FAIL hold_idle_gap: got busy %b done %b want 0/0", busy_o, done_o);
    end
    n_cmp++;
    if (out_data_q.size() != DEPTH) begin
      n_bad++; $display("FAIL hold_out_count: got %0d want %0d", out_data_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        n_cmp++;
        if (out_data_q[i] !== exp_word(i, 2)) begin
          n_bad++; $display("FAIL hold_out[%0d]: got %0d want %0d", i, out_data_q[i], exp_word(i, 2));
        end
      end
    end
    run_job(1, 100, 0, 1'b1, 1'b0, -1, to, ab);
    start_i = 1'b0;
    n_cmp++;
    if (to || done_cnt != 1 || wv_cnt != DEPTH || out_data_q.size() != DEPTH) begin
      n_bad++;
      $display("FAIL hold_job2: got to %b done %0d wv %0d words %0d want 0/1/%0d/%0d",
               to, done_cnt, wv_cnt, out_data_q.size(), DEPTH, DEPTH);
      if (to) do_reset();
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        n_cmp++;
        if (out_data_q[i] !== exp_word(i, 1)) begin
          n_bad++; $display("FAIL hold2_out[%0d]: got %0d want %0d", i, out_data_q[i], exp_word(i, 1));
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_i = 1'b0; start_i = 1'b0; passes_i = '0;
    bias_data_i = '0; bias_valid_i = 1'b0;
    psum_data_i = '0; psum_valid_i = 1'b0; out_ready_i = 1'b0;
    bias_hs = 0; psum_hs = 0; wv_cnt = 0; overlap_cnt = 0; stray_cnt = 0; done_cnt = 0;
    bp_seen = 1'b0; bp_bad = 0; bp_data = '0;
    test_reset();
    test_bias_only();
    test_accum();
    test_backpressure();
    test_gapped();
    test_reset_mid_accum();
    test_ignored_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
